noc_output_arbiter: RTL and testbench
=====================================

Name: noc_output_arbiter

Overview:
- Per-output-port wormhole arbiter for the NoC router; one instance sits in front of each output port buffer.
- Shares one output port between NUM_IN input ports using round-robin arbitration.
- Locks the winning input until its tail flit is transferred, then releases the port.
- Drives the output port's push enable and data, and respects the output buffer's full flag.

Parameters:
- NUM_IN, 5, number of requesting input ports (N, E, S, W, Local).
- FLIT_W, 16, flit width in bits.
- CNT_W, 16, width of the packet statistics counter (used only with the optional feature).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req_i  input  NUM_IN  input i has a flit for this output port.
- last_i  input  NUM_IN  input i's current flit is a tail flit.
- data_i  input  NUM_IN*FLIT_W  flattened flits; input i occupies bits [i*FLIT_W +: FLIT_W].
- out_full_i  input  1  output port buffer is full.
- grant_o  output  NUM_IN  one-hot owner of the port; all zeros when idle.
- port_en_o  output  1  push enable to the output port buffer; one flit transferred this cycle.
- data_o  output  FLIT_W  selected flit to the output port buffer.
- busy_o  output  1  port is locked to an owner.

Behaviour:
- Reset: state IDLE, rr_ptr=0, owner=0, grant_o=0, busy_o=0, port_en_o=0, data_o=0 (data_o is zero whenever port_en_o=0).
- Two states: IDLE and LOCKED.
- IDLE: if any req_i bit is set, the winner is the first set bit searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_IN.
  - At the clock edge: owner <= winner, state <= LOCKED.
  - No flit is transferred in the IDLE cycle. Arbitration latency is 1 cycle from request to grant.
- LOCKED: grant_o=onehot(owner), busy_o=1.
  - Transfer: port_en_o = req_i[owner] && !out_full_i; data_o = data_i[owner] during a transfer.
  - Tail release: on a transfer with last_i[owner]=1, next state IDLE and rr_ptr <= (owner+1) mod NUM_IN. This costs exactly one idle bubble cycle between packets.
- Owner deasserts req mid-packet: stay LOCKED, no transfer. Other requesters stay blocked (wormhole semantics).
- out_full_i=1: port_en_o must be 0, with no exception. The lock is held.
- Single-flit packet (first flit has last set): granted, then one transfer, then release.
- Requests from non-owners while LOCKED are ignored. Changes to non-owner inputs never affect port_en_o.
- rst asserted mid-packet: the in-flight packet is abandoned and all state returns to reset values on the next edge.
- rr_ptr arithmetic: wraps from NUM_IN-1 to 0. Only values 0..NUM_IN-1 are legal (assertion).
- Assertions:
  - grant_o is one-hot or zero.
  - port_en_o implies !out_full_i.
  - port_en_o implies busy_o.

Optional Feature:
- Macro: NOC_ARB_STATS_EN.
- Defined: adds output port pkt_cnt_o [CNT_W].
  - Increments by 1 on each tail transfer.
  - Saturates at all-ones.
  - Cleared by rst.
- Undefined: the port and the counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package noc_pkg:
  - NUM_PORTS=5 and FLIT_W=16 constants.
  - port_idx_t enum (NORTH, EAST, SOUTH, WEST, LOCAL).
  - arb_state_t enum {IDLE, LOCKED}.
- Sub-module noc_rr_picker: purely combinational rotating-priority encoder.
  - Inputs: req vector and rr_ptr.
  - Outputs: winner index and a valid flag.
- The FSM, lock, mux and counter stay in noc_output_arbiter.

Test Plan:
- Reset, then req_i=5'b00100 with last=1 on the first flit, out_full_i=0:
  - grant_o=5'b00100 on cycle 2.
  - One port_en_o pulse with data_o=data_i[2].
  - Back to IDLE, rr_ptr=3.
- All five inputs request 2-flit packets continuously from reset:
  - Grants in order 0, 1, 2, 3, 4, 0.
  - Each owner gets exactly 2 transfers, with 1 bubble cycle between packets.
- Owner 1 mid-packet with out_full_i=1 for 3 cycles while input 3 requests:
  - port_en_o=0 for those 3 cycles.
  - grant_o stays 5'b00010 and the packet resumes when full drops.
- Owner 4 drops req_i[4] for 2 cycles mid-packet:
  - No transfers and no re-grant during the gap.
  - Tail then releases and rr_ptr wraps to 0.
- rst pulsed while locked to input 2 after 1 of 3 flits:
  - Next cycle grant_o=0, busy_o=0, port_en_o=0.
  - Fresh arbitration starts from rr_ptr=0.
- With NOC_ARB_STATS_EN defined and CNT_W=2, send 5 packets:
  - pkt_cnt_o reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router constants and enumerations.
package noc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int FLIT_W    = 16;

  typedef enum logic [2:0] {NORTH, EAST, SOUTH, WEST, LOCAL} port_idx_t;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

endpackage

// File: rtl/noc_rr_picker.sv
// Combinational rotating-priority encoder: the first set request at or after ptr_i wins.
module noc_rr_picker
  import noc_pkg::*;
#(
  parameter int N  = NUM_PORTS,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] winner_o,
  output logic          vld_o
);

  always_comb begin
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    winner_o = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        winner_o = PW'(idx);
        found    = 1'b1;
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Per-output-port wormhole round-robin arbiter; NOC_ARB_STATS_EN adds a
// saturating tail-flit packet counter on pkt_cnt_o.
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_IN = NUM_PORTS,
  parameter int FLIT_W = noc_pkg::FLIT_W,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req_i,
  input  logic [NUM_IN-1:0]        last_i,
  input  logic [NUM_IN*FLIT_W-1:0] data_i,
  input  logic                     out_full_i,
  output logic [NUM_IN-1:0]        grant_o,
  output logic                     port_en_o,
  output logic [FLIT_W-1:0]        data_o,
  output logic                     busy_o
`ifdef NOC_ARB_STATS_EN
  ,output logic [CNT_W-1:0]        pkt_cnt_o
`endif
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_vld;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_IN - 1)) ? '0 : p + 1'b1;
  endfunction

  noc_rr_picker #(
    .N  (NUM_IN),
    .PW (PTR_W)
  ) u_picker (
    .req_i    (req_i),
    .ptr_i    (rr_ptr_q),
    .winner_o (pick_idx),
    .vld_o    (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // The owner holds the port across stalls and request gaps until its tail leaves.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    grant_o   = '0;
    busy_o    = 1'b0;
    port_en_o = 1'b0;
    data_o    = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        grant_o[owner_q] = 1'b1;
        busy_o           = 1'b1;
        if (req_i[owner_q] && !out_full_i) begin
          port_en_o = 1'b1;
          data_o    = data_i[int'(owner_q)*FLIT_W +: FLIT_W];
          if (last_i[owner_q]) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef NOC_ARB_STATS_EN
  logic [CNT_W-1:0] pkt_cnt_q;
  logic             tail_xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign tail_xfer = port_en_o && last_i[owner_q];

  always_ff @(posedge clk) begin
    if (rst)            pkt_cnt_q <= '0;
    else if (tail_xfer) pkt_cnt_q <= sat_inc(pkt_cnt_q);
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

  a_params:       assert property (@(posedge clk) disable iff (rst) (NUM_IN >= 2) && (CNT_W >= 1));
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_o));
  a_en_not_full:  assert property (@(posedge clk) disable iff (rst) port_en_o |-> !out_full_i);
  a_en_busy:      assert property (@(posedge clk) disable iff (rst) port_en_o |-> busy_o);
  a_rr_legal:     assert property (@(posedge clk) disable iff (rst) int'(rr_ptr_q) < NUM_IN);

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Scoreboard bench for noc_output_arbiter; pkt_cnt_o checks compile in with NOC_ARB_STATS_EN.
module tb_noc_output_arbiter;

  localparam int N  = 5;
  localparam int FW = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [N-1:0]    last_i;
  logic [N*FW-1:0] data_i;
  logic            out_full_i;
  logic [N-1:0]    grant_o;
  logic            port_en_o;
  logic [FW-1:0]   data_o;
  logic            busy_o;
`ifdef NOC_ARB_STATS_EN
  logic [1:0]      pkt_cnt_o;
`endif

  noc_output_arbiter #(
    .NUM_IN (N),
    .FLIT_W (FW),
    .CNT_W  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .last_i     (last_i),
    .data_i     (data_i),
    .out_full_i (out_full_i),
    .grant_o    (grant_o),
    .port_en_o  (port_en_o),
    .data_o     (data_o),
    .busy_o     (busy_o)
`ifdef NOC_ARB_STATS_EN
    ,.pkt_cnt_o (pkt_cnt_o)
`endif
  );

  typedef struct {
    int            cyc;
    logic [N-1:0]  grant;
    logic [FW-1:0] data;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp;
  int   n_fail;
  int   cyc;

  // Per-input source model: packets remaining, length, current flit, packet number.
  int       s_pkts[N];
  int       s_len[N];
  int       s_f[N];
  int       s_p[N];
  logic [N-1:0] hold_cfg;
  logic     full_cfg;
  logic     rst_cfg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [FW-1:0] mkflit(input int i, input int p, input int f);
    return {4'hA, i[3:0], p[3:0], f[3:0]};
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    return N'(1 << i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [N-1:0] g, input logic [FW-1:0] d);
    exp_t e;
    e.cyc = c; e.grant = g; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic setsrc(input int i, input int pkts, input int len, input int p);
    s_pkts[i] = pkts; s_len[i] = len; s_f[i] = 0; s_p[i] = p;
  endtask

  task automatic clr_src();
    for (int i = 0; i < N; i++) setsrc(i, 0, 1, 0);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_i[i]             = (s_pkts[i] > 0) && !hold_cfg[i];
      last_i[i]            = (s_f[i] == s_len[i] - 1);
      data_i[i*FW +: FW]   = mkflit(i, s_p[i], s_f[i]);
    end
    out_full_i = full_cfg;
    rst        = rst_cfg;
  endtask

  // One cycle: observe the transfer, then after the edge advance sources and drive.
  task automatic step();
    logic         xf;
    logic [N-1:0] g;
    @(negedge clk);
    xf = port_en_o && !rst;
    g  = grant_o;
    @(posedge clk);
    #1;
    if (xf) begin
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          s_f[i]++;
          if (s_f[i] == s_len[i]) begin
            s_f[i] = 0;
            s_p[i]++;
            s_pkts[i]--;
          end
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst_cfg = 1'b1;
    clr_src();
    step();
    step();
    rst_cfg = 1'b0;
    drive();
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("en_vs_full", 32'(port_en_o & out_full_i), 32'd0);
      if (port_en_o) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected: got transfer data %0h grant %0h expected none (cycle %0d)",
                   data_o, grant_o, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_cycle", cyc, e.cyc);
          chk("sb_grant", 32'(grant_o), 32'(e.grant));
          chk("sb_data", 32'(data_o), 32'(e.data));
        end
      end else begin
        chk("data_idle", 32'(data_o), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
`ifdef NOC_ARB_STATS_EN
    int exp_cnt[5];
    exp_cnt = '{1, 2, 3, 3, 3};
`endif
    n_cmp = 0; n_fail = 0;
    hold_cfg = '0; full_cfg = 1'b0; rst_cfg = 1'b1;
    clr_src();
    drive();

    // Reset state
    do_reset();
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_en", 32'(port_en_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);

    // Single-flit packet from input 2
    setsrc(2, 1, 1, 0);
    drive(); #1; t = cyc;
    push(t + 1, 5'b00100, mkflit(2, 0, 0));
    chk("t1_arb_grant", 32'(grant_o), 32'd0);
    step();
    chk("t1_grant", 32'(grant_o), 32'b00100);
    chk("t1_busy", 32'(busy_o), 32'd1);
    chk("t1_en", 32'(port_en_o), 32'd1);
    step();
    chk("t1_rel_grant", 32'(grant_o), 32'd0);
    chk("t1_rel_busy", 32'(busy_o), 32'd0);
    // rr_ptr is now 3: input 3 beats input 0, then 0 follows after the wrap
    setsrc(0, 1, 1, 0);
    setsrc(3, 1, 1, 0);
    drive(); #1; t = cyc;
    push(t + 1, 5'b01000, mkflit(3, 0, 0));
    push(t + 3, 5'b00001, mkflit(0, 0, 0));
    repeat (4) step();

    // All five inputs, two 2-flit packets each
    do_reset();
    for (int i = 0; i < N; i++) setsrc(i, 2, 2, 0);
    drive(); #1; t = cyc;
    for (int k = 0; k < 10; k++) begin
      push(t + 3*k + 1, oh(k % 5), mkflit(k % 5, k / 5, 0));
      push(t + 3*k + 2, oh(k % 5), mkflit(k % 5, k / 5, 1));
    end
    repeat (31) step();

    // Output full for 3 cycles mid-packet while input 3 waits
    do_reset();
    setsrc(1, 1, 3, 0);
    setsrc(3, 1, 1, 0);
    drive(); #1; t = cyc;
    push(t + 1, 5'b00010, mkflit(1, 0, 0));
    push(t + 5, 5'b00010, mkflit(1, 0, 1));
    push(t + 6, 5'b00010, mkflit(1, 0, 2));
    push(t + 8, 5'b01000, mkflit(3, 0, 0));
    step();
    full_cfg = 1'b1;
    repeat (3) begin
      step();
      chk("full_en", 32'(port_en_o), 32'd0);
      chk("full_grant", 32'(grant_o), 32'b00010);
    end
    full_cfg = 1'b0;
    repeat (5) step();

    // Owner 4 drops its request for 2 cycles; tail then wraps rr_ptr to 0
    do_reset();
    setsrc(4, 1, 3, 0);
    drive(); #1; t = cyc;
    push(t + 1, 5'b10000, mkflit(4, 0, 0));
    push(t + 4, 5'b10000, mkflit(4, 0, 1));
    push(t + 5, 5'b10000, mkflit(4, 0, 2));
    push(t + 7, 5'b00001, mkflit(0, 0, 0));
    push(t + 9, 5'b01000, mkflit(3, 0, 0));
    step();
    hold_cfg = 5'b10000;
    setsrc(0, 1, 1, 0);
    setsrc(3, 1, 1, 0);
    repeat (2) begin
      step();
      chk("gap_en", 32'(port_en_o), 32'd0);
      chk("gap_grant", 32'(grant_o), 32'b10000);
    end
    hold_cfg = '0;
    repeat (7) step();

    // Reset mid-packet (rr_ptr is 4 beforehand); arbitration restarts from 0
    setsrc(2, 1, 3, 0);
    drive(); #1; t = cyc;
    push(t + 1, 5'b00100, mkflit(2, 0, 0));
    step();
    rst_cfg = 1'b1;
    step();
    clr_src();
    setsrc(2, 1, 1, 1);
    setsrc(4, 1, 1, 0);
    rst_cfg = 1'b0;
    step();
    chk("mrst_grant", 32'(grant_o), 32'd0);
    chk("mrst_busy", 32'(busy_o), 32'd0);
    chk("mrst_en", 32'(port_en_o), 32'd0);
    push(t + 4, 5'b00100, mkflit(2, 1, 0));
    push(t + 6, 5'b10000, mkflit(4, 0, 0));
    repeat (4) step();

    // Five single-flit packets; counter saturates at 3
    do_reset();
`ifdef NOC_ARB_STATS_EN
    chk("cnt_rst", 32'(pkt_cnt_o), 32'd0);
`endif
    for (int i = 0; i < N; i++) setsrc(i, 1, 1, 0);
    drive(); #1; t = cyc;
    for (int k = 0; k < 5; k++) push(t + 2*k + 1, oh(k), mkflit(k, 0, 0));
    for (int k = 0; k < 5; k++) begin
      step();
      step();
`ifdef NOC_ARB_STATS_EN
      chk("pkt_cnt", 32'(pkt_cnt_o), 32'(exp_cnt[k]));
`endif
    end
    repeat (2) step();

    chk("sb_drain", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
